// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the stage
// registers it controls: FSM state encoding, the NOP instruction loaded on a
// flush, and the bundle of per-stage control strobes.
package pipe_ctrl_pkg;

    // Sequencer states: normal advance, or holding IF/ID/EX for a mul/div.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1
    } state_t;

    // sll $0,$0,0 -- the word stage registers load when flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Per-stage control strobes driven by the sequencer.
    typedef struct packed {
        logic pc_we;
        logic we_if_id;
        logic we_id_ex;
        logic we_ex_mem;
        logic we_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic bubble_ex_mem;
    } ctrl_t;

    // Every stage advances, nothing is squashed.
    function automatic ctrl_t ctrl_advance();
        ctrl_t c;
        c.pc_we         = 1'b1;
        c.we_if_id      = 1'b1;
        c.we_id_ex      = 1'b1;
        c.we_ex_mem     = 1'b1;
        c.we_mem_wb     = 1'b1;
        c.flush_if_id   = 1'b0;
        c.flush_id_ex   = 1'b0;
        c.bubble_ex_mem = 1'b0;
        return c;
    endfunction

    // Whole pipeline frozen (data memory not ready), nothing is squashed.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c.pc_we         = 1'b0;
        c.we_if_id      = 1'b0;
        c.we_id_ex      = 1'b0;
        c.we_ex_mem     = 1'b0;
        c.we_mem_wb     = 1'b0;
        c.flush_if_id   = 1'b0;
        c.flush_id_ex   = 1'b0;
        c.bubble_ex_mem = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up on inc, stick at all-ones, clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges data-memory
// wait, mul/div occupancy, taken-branch flush and load-use stall into the
// per-stage write enables, and keeps a saturating count of frozen-PC cycles.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken_EX,
    input  logic             muldiv_start_EX,
    input  logic             muldiv_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             stat_clr,
    output logic             pc_WE,
    output logic             WE_if_id,
    output logic             WE_id_ex,
    output logic             WE_ex_mem,
    output logic             WE_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             muldiv_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int             WAIT_W    = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    logic  w_mem_wait;
    logic  w_in_muldiv;
    logic  w_at_limit;
    logic  w_md_exit;
    logic  w_md_abort;
    ctrl_t w_ctrl;

    assign w_mem_wait  = dmem_req & ~dmem_ready;
    assign w_in_muldiv = (r_state == ST_MULDIV);
    assign w_at_limit  = (r_wait_cnt == WAIT_LAST);
    // Exit cycle of a mul/div: the result is ready or we give up on it.
    assign w_md_exit   = w_in_muldiv & ~w_mem_wait & (muldiv_done | w_at_limit);
    assign w_md_abort  = w_md_exit & ~muldiv_done;

    // Output decode: memory wait freezes everything; otherwise the state picks
    // the hold pattern, and branch/load-use only act while EX really advances.
    always_comb begin
        w_ctrl = ctrl_advance();
        if (w_mem_wait) begin
            w_ctrl = ctrl_freeze();
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_EX) begin
                        // Wrong-path fetch is squashed; a pending load-use stall is moot.
                        w_ctrl.flush_if_id = 1'b1;
                        w_ctrl.flush_id_ex = 1'b1;
                    end else if (load_use_stall) begin
                        w_ctrl.pc_we       = 1'b0;
                        w_ctrl.we_if_id    = 1'b0;
                        w_ctrl.flush_id_ex = 1'b1;
                    end else begin
                        w_ctrl = ctrl_advance();
                    end
                end
                ST_MULDIV: begin
                    if (w_md_exit) begin
                        if (branch_taken_EX) begin
                            w_ctrl.flush_if_id = 1'b1;
                            w_ctrl.flush_id_ex = 1'b1;
                        end else begin
                            w_ctrl = ctrl_advance();
                        end
                    end else begin
                        // Hold the mul/div in EX and let MEM/WB drain behind bubbles.
                        w_ctrl.pc_we         = 1'b0;
                        w_ctrl.we_if_id      = 1'b0;
                        w_ctrl.we_id_ex      = 1'b0;
                        w_ctrl.bubble_ex_mem = 1'b1;
                    end
                end
                default: begin
                    w_ctrl = ctrl_advance();
                end
            endcase
        end
    end

    // Sequencer FSM with its wait counter and the sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= {WAIT_W{1'b0}};
            r_timeout_err <= 1'b0;
        end else if (!w_mem_wait) begin
            case (r_state)
                ST_RUN: begin
                    // A branch in EX wins over a (malformed) concurrent mul/div start.
                    if (muldiv_start_EX && !branch_taken_EX) begin
                        r_state    <= ST_MULDIV;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end
                end
                ST_MULDIV: begin
                    if (w_md_exit) begin
                        r_state <= ST_RUN;
                        if (w_md_abort) begin
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~w_ctrl.pc_we),
        .clr (stat_clr),
        .q   (stall_count)
    );

    assign pc_WE         = w_ctrl.pc_we;
    assign WE_if_id      = w_ctrl.we_if_id;
    assign WE_id_ex      = w_ctrl.we_id_ex;
    assign WE_ex_mem     = w_ctrl.we_ex_mem;
    assign WE_mem_wb     = w_ctrl.we_mem_wb;
    assign flush_if_id   = w_ctrl.flush_if_id;
    assign flush_id_ex   = w_ctrl.flush_id_ex;
    assign bubble_ex_mem = w_ctrl.bubble_ex_mem;
    assign muldiv_busy   = w_in_muldiv;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the rules.
module tb_pipeline_stall_controller;

    localparam int TO    = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_use_stall = 1'b0;
    logic          branch_taken_EX = 1'b0;
    logic          muldiv_start_EX = 1'b0;
    logic          muldiv_done = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          stat_clr = 1'b0;
    logic          pc_WE, WE_if_id, WE_id_ex, WE_ex_mem, WE_mem_wb;
    logic          flush_if_id, flush_id_ex, bubble_ex_mem, muldiv_busy, timeout_err;
    logic [CW-1:0] stall_count;

    pipeline_stall_controller #(
        .MULDIV_TIMEOUT (TO),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_use_stall  (load_use_stall),
        .branch_taken_EX (branch_taken_EX),
        .muldiv_start_EX (muldiv_start_EX),
        .muldiv_done     (muldiv_done),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .stat_clr        (stat_clr),
        .pc_WE           (pc_WE),
        .WE_if_id        (WE_if_id),
        .WE_id_ex        (WE_id_ex),
        .WE_ex_mem       (WE_ex_mem),
        .WE_mem_wb       (WE_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .bubble_ex_mem   (bubble_ex_mem),
        .muldiv_busy     (muldiv_busy),
        .timeout_err     (timeout_err),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: is a mul/div occupying EX, how many productive
    // cycles it has spent there, the sticky error and the stall tally.
    bit m_md     = 1'b0;
    int m_active = 0;
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    logic [8:0] last_obs;

    // Reset pattern {pc,ifid,idex,exmem,memwb,fl_ifid,fl_idex,bubble,busy}.
    localparam logic [8:0] RESET_OUTS = 9'b11111_000_0;

    function automatic logic [8:0] dut_outs();
        return {pc_WE, WE_if_id, WE_id_ex, WE_ex_mem, WE_mem_wb,
                flush_if_id, flush_id_ex, bubble_ex_mem, muldiv_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected strobes for this cycle, straight from the stall/flush rules.
    function automatic logic [8:0] model_outs(input bit lu, input bit br, input bit md,
                                              input bit rq, input bit rd);
        bit frozen = rq && !rd;
        bit ex_moves = !m_md || md || (m_active + 1 == TO);
        bit pc, ifid, idex, exm, mwb, fif, fid, bub;
        pc = 1; ifid = 1; idex = 1; exm = 1; mwb = 1; fif = 0; fid = 0; bub = 0;
        if (frozen) begin
            {pc, ifid, idex, exm, mwb} = 5'b00000;
        end else if (!ex_moves) begin
            {pc, ifid, idex} = 3'b000;
            bub = 1;
        end else if (br) begin
            fif = 1; fid = 1;
        end else if (!m_md && lu) begin
            pc = 0; ifid = 0; fid = 1;
        end
        return {pc, ifid, idex, exm, mwb, fif, fid, bub, m_md};
    endfunction

    // One clock: apply inputs, check combinational outputs against the model,
    // clock, then advance the model.
    task automatic drive(input bit lu, input bit br, input bit ms, input bit md,
                         input bit rq, input bit rd, input bit cl);
        logic [8:0] exp;
        bit frozen;
        load_use_stall  = lu;
        branch_taken_EX = br;
        muldiv_start_EX = ms;
        muldiv_done     = md;
        dmem_req        = rq;
        dmem_ready      = rd;
        stat_clr        = cl;
        #2;
        exp      = model_outs(lu, br, md, rq, rd);
        last_obs = dut_outs();
        chk("outs", 32'(last_obs), 32'(exp));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        @(posedge clk);
        frozen = rq && !rd;
        if (!frozen) begin
            if (m_md) begin
                if (md || (m_active + 1 == TO)) begin
                    m_md = 1'b0;
                    if (!md) m_err = 1'b1;
                end else begin
                    m_active++;
                end
            end else if (ms && !br) begin
                m_md     = 1'b1;
                m_active = 0;
            end
        end
        if (cl) m_cnt = 0;
        else if (!exp[8] && m_cnt < CMAX) m_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {load_use_stall, branch_taken_EX, muldiv_start_EX, muldiv_done} = 4'b0000;
        {dmem_req, dmem_ready, stat_clr} = 3'b000;
        #2;
        chk("rst_outs", 32'(dut_outs()), 32'(RESET_OUTS));
        chk("rst_count", 32'(stall_count), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_md = 1'b0; m_active = 0; m_err = 1'b0; m_cnt = 0;
    endtask

    initial begin
        int busy_n, bub_n;
        @(posedge clk);
        #1;
        do_reset();
        idle(2);
        chk("idle_count", 32'(stall_count), 32'd0);

        // Single load-use bubble.
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("lu_outs", 32'(last_obs), 32'(9'b00111_010_0));
        chk("lu_count", 32'(stall_count), 32'd1);

        // Branch cancels a simultaneous load-use.
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("br_lu_outs", 32'(last_obs), 32'(9'b11111_110_0));
        chk("br_lu_count", 32'(stall_count), 32'd1);

        // Mul/div completing on its 5th cycle.
        drive(0, 0, 1, 0, 0, 0, 0);
        busy_n = 0; bub_n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, (i == 4), 0, 0, 0);
            busy_n += int'(last_obs[0]);
            bub_n  += int'(last_obs[1]);
        end
        chk("md_busy_cycles", 32'(busy_n), 32'd5);
        chk("md_bubble_cycles", 32'(bub_n), 32'd4);
        chk("md_count", 32'(stall_count), 32'd5);
        chk("md_back_run", 32'(muldiv_busy), 32'd0);

        // Clear the tally, then a mul/div interrupted by 3 memory-wait cycles.
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("clr_count", 32'(stall_count), 32'd0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("mw_freeze", 32'(last_obs), 32'(9'b00000_000_1));
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("mw_done_ignored", 32'(muldiv_busy), 32'd1);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("mw_exit_outs", 32'(last_obs), 32'(9'b11111_000_1));
        chk("mw_count", 32'(stall_count), 32'd4);
        chk("mw_back_run", 32'(muldiv_busy), 32'd0);

        // Mul/div that never finishes: abort after TO cycles in MULDIV.
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(TO);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_back_run", 32'(muldiv_busy), 32'd0);
        chk("to_count", 32'(stall_count), 32'(4 + TO - 1));
        idle(1);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        chk("to_rst_clears", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a mul/div.
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(muldiv_busy), 32'd0);
        chk("async_count", 32'(stall_count), 32'd0);
        do_reset();

        // Saturation of the stall tally.
        for (int i = 0; i < CMAX + 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
        chk("sat_count", 32'(stall_count), 32'(CMAX));
        idle(1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(3) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(1) == 0),
                  ($urandom_range(24) == 0));
            if ($urandom_range(199) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
